// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam int         DEF_MEM_TIMEOUT = 15;
    localparam logic [4:0] REG_ZERO        = 5'd0;

endpackage

// File: rtl/hazard_loaduse_detect.sv
// Load-use hazard comparator: flags an ID source that depends on a load still in EX.
// Purely combinational; register zero never creates a dependency.
module hazard_loaduse_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rt,
    output logic       hit
);

    assign hit = ex_mem_read && (ex_rt != REG_ZERO) &&
                 ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; Mealy outputs, zero latency.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TO_W        = 4
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W       = 16
`endif
)(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRt,
    input  logic       ID_Jump,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_Rt,
    input  logic       EX_BranchTaken,
    input  logic       MEM_MemReq,
    input  logic       MemReady,
    output logic       PC_Ld,
    output logic       IFID_Ld,
    output logic       IDEX_Ld,
    output logic       EXMEM_Ld,
    output logic       MEMWB_Ld,
    output logic       IFID_Flush,
    output logic       IDEX_Flush,
    output logic       MEMWB_Flush,
    output logic       MemTimeout,
    output logic       WaitState
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
`endif
);

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    logic            lu_hit;
    logic            freeze;
    logic            timeout_hit;
    logic [4:0]      ld;
    logic [2:0]      fl;

    hazard_loaduse_detect u_lu (
        .id_rs       (ID_Rs),
        .id_rt       (ID_Rt),
        .id_uses_rt  (ID_UsesRt),
        .ex_mem_read (EX_MemRead),
        .ex_rt       (EX_Rt),
        .hit         (lu_hit)
    );

    assign freeze      = MEM_MemReq && !MemReady;
    assign timeout_hit = (state == MEM_WAIT) && !MemReady &&
                         (wait_cnt == TO_W'(MEM_TIMEOUT));

    // ld = {PC, IFID, IDEX, EXMEM, MEMWB}; fl = {IFID, IDEX, MEMWB}
    always_comb begin
        ld = 5'b11111;
        fl = 3'b000;
        if (EX_BranchTaken) begin
            fl = 3'b110;
        end else if (ID_Jump) begin
            fl = 3'b100;
        end else if (lu_hit) begin
            ld = 5'b00111;
            fl = 3'b010;
        end

        if (!Rst) begin
            ld = 5'b00000;
            fl = 3'b111;
        end else if (state == RUN) begin
            if (freeze) begin
                ld = 5'b00000;
                fl = 3'b000;
            end
        end else if (!MemReady) begin
            // Abort: drop the stuck access by clearing MEM/WB and let everything advance.
            ld = timeout_hit ? 5'b11111 : 5'b00000;
            fl = timeout_hit ? 3'b001 : 3'b000;
        end
    end

    assign {PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld} = ld;
    assign {IFID_Flush, IDEX_Flush, MEMWB_Flush}          = fl;
    assign WaitState = (state == MEM_WAIT);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state      <= RUN;
            wait_cnt   <= '0;
            MemTimeout <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= TO_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (MemReady) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (timeout_hit) begin
                        state      <= RUN;
                        wait_cnt   <= '0;
                        MemTimeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            StallCycles <= '0;
            FlushCount  <= '0;
        end else begin
            if (!PC_Ld && (StallCycles != '1))
                StallCycles <= StallCycles + CNT_W'(1);
            if (IFID_Flush && (FlushCount != '1))
                FlushCount <= FlushCount + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors push expected controls, a negedge monitor compares.
module tb_pipeline_hazard_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [4:0] ID_Rs, ID_Rt, EX_Rt;
    logic       ID_UsesRt, ID_Jump, EX_MemRead, EX_BranchTaken, MEM_MemReq, MemReady;
    logic       PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld;
    logic       IFID_Flush, IDEX_Flush, MEMWB_Flush, MemTimeout, WaitState;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] StallCycles, FlushCount;
`endif

    pipeline_hazard_ctrl dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .ID_Rs          (ID_Rs),
        .ID_Rt          (ID_Rt),
        .ID_UsesRt      (ID_UsesRt),
        .ID_Jump        (ID_Jump),
        .EX_MemRead     (EX_MemRead),
        .EX_Rt          (EX_Rt),
        .EX_BranchTaken (EX_BranchTaken),
        .MEM_MemReq     (MEM_MemReq),
        .MemReady       (MemReady),
        .PC_Ld          (PC_Ld),
        .IFID_Ld        (IFID_Ld),
        .IDEX_Ld        (IDEX_Ld),
        .EXMEM_Ld       (EXMEM_Ld),
        .MEMWB_Ld       (MEMWB_Ld),
        .IFID_Flush     (IFID_Flush),
        .IDEX_Flush     (IDEX_Flush),
        .MEMWB_Flush    (MEMWB_Flush),
        .MemTimeout     (MemTimeout),
        .WaitState      (WaitState)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .StallCycles    (StallCycles),
        .FlushCount     (FlushCount)
`endif
    );

    always #5 Clk = ~Clk;

    // {PC,IFID,IDEX,EXMEM,MEMWB Ld, IFID,IDEX,MEMWB Flush, MemTimeout, WaitState}
    localparam logic [9:0] E_RST  = 10'b00000_111_0_0;
    localparam logic [9:0] E_NORM = 10'b11111_000_0_0;
    localparam logic [9:0] E_LU   = 10'b00111_010_0_0;
    localparam logic [9:0] E_BR   = 10'b11111_110_0_0;
    localparam logic [9:0] E_JMP  = 10'b11111_100_0_0;
    localparam logic [9:0] E_FRZ  = 10'b00000_000_0_0;
    localparam logic [9:0] E_ABRT = 10'b11111_001_0_0;
    localparam logic [9:0] B_TO   = 10'b00000_000_1_0;
    localparam logic [9:0] B_WS   = 10'b00000_000_0_1;

    typedef struct {
        logic [9:0] v;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    wire [9:0] got = {PC_Ld, IFID_Ld, IDEX_Ld, EXMEM_Ld, MEMWB_Ld,
                      IFID_Flush, IDEX_Flush, MEMWB_Flush, MemTimeout, WaitState};

    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (got !== e.v) begin
                failures++;
                $display("FAIL %s: got %b expected %b", e.name, got, e.v);
            end
        end
    end

    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                        input logic jmp, input logic mrd, input logic [4:0] ert,
                        input logic br, input logic req, input logic rdy,
                        input logic [9:0] ev, input string nm);
        exp_t e;
        ID_Rs = rs; ID_Rt = rt; ID_UsesRt = urt; ID_Jump = jmp;
        EX_MemRead = mrd; EX_Rt = ert; EX_BranchTaken = br;
        MEM_MemReq = req; MemReady = rdy;
        e.v = ev;
        e.name = nm;
        exp_q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input logic [9:0] ev, input string nm);
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ev, nm);
    endtask

    task automatic mem_stall(input logic rdy, input logic [9:0] ev, input string nm);
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, rdy, ev, nm);
    endtask

    task automatic loaduse(input logic [9:0] ev, input string nm);
        step(5'd8, 5'd2, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, ev, nm);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b0;
        ID_Rs = '0; ID_Rt = '0; ID_UsesRt = 1'b0; ID_Jump = 1'b0;
        EX_MemRead = 1'b0; EX_Rt = '0; EX_BranchTaken = 1'b0;
        MEM_MemReq = 1'b0; MemReady = 1'b0;
        @(posedge Clk);
        #1;
        idle(E_RST, "reset_state");
        Rst = 1'b1;
        idle(E_NORM, "normal");

        // load-use on Rs, then bubble clears the load
        loaduse(E_LU, "loaduse_rs");
        idle(E_NORM, "after_loaduse");
        step(5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_NORM, "loaduse_r0");
        step(5'd3, 5'd9, 1'b1, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, E_LU,   "loaduse_rt");
        step(5'd3, 5'd9, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, E_NORM, "rt_unused");

        // branch and jump both override the load-use stall
        step(5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, E_BR,   "branch_over_lu");
        step(5'd8, 5'd0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, E_JMP,  "jump_over_lu");
        step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, E_BR,   "branch_over_jump");

        // memory wait released by ready on the fourth cycle
        mem_stall(1'b0, E_FRZ, "freeze_run");
        mem_stall(1'b0, E_FRZ | B_WS, "wait_1");
        mem_stall(1'b0, E_FRZ | B_WS, "wait_2");
        mem_stall(1'b1, E_NORM | B_WS, "wait_release");
        idle(E_NORM, "after_release");

        // reset while waiting with the counter at 5
        mem_stall(1'b0, E_FRZ, "freeze_pre_rst");
        for (int i = 1; i <= 4; i++) mem_stall(1'b0, E_FRZ | B_WS, "wait_pre_rst");
        Rst = 1'b0;
        mem_stall(1'b0, E_RST, "rst_mid_wait");
        Rst = 1'b1;
        idle(E_NORM, "post_rst_run");

        // ready arriving exactly at the timeout limit wins
        mem_stall(1'b0, E_FRZ, "freeze_limit");
        for (int i = 1; i <= 14; i++) mem_stall(1'b0, E_FRZ | B_WS, "wait_limit");
        mem_stall(1'b1, E_NORM | B_WS, "ready_at_limit");
        idle(E_NORM, "no_error_at_limit");

        // true timeout: abort cycle, then sticky flag
        mem_stall(1'b0, E_FRZ, "freeze_to");
        for (int i = 1; i <= 14; i++) mem_stall(1'b0, E_FRZ | B_WS, "wait_to");
        mem_stall(1'b0, E_ABRT | B_WS, "timeout_abort");
        idle(E_NORM | B_TO, "timeout_sticky");
        loaduse(E_LU | B_TO, "sticky_loaduse");

        // fresh reset clears the flag; then 3 stalls and 2 jumps
        Rst = 1'b0;
        idle(E_RST, "reset_again");
        Rst = 1'b1;
        loaduse(E_LU, "perf_lu1");
        idle(E_NORM, "perf_gap");
        loaduse(E_LU, "perf_lu2");
        loaduse(E_LU, "perf_lu3");
        step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_JMP, "perf_jmp1");
        step(5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_JMP, "perf_jmp2");
        idle(E_NORM, "perf_end");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge Clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

`ifdef HAZARD_PERF_CNT_EN
        checks++;
        if (StallCycles !== 16'd3) begin
            failures++;
            $display("FAIL stall_cycles: got %0d expected 3", StallCycles);
        end
        checks++;
        if (FlushCount !== 16'd2) begin
            failures++;
            $display("FAIL flush_count: got %0d expected 2", FlushCount);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
